// File: rtl/system_flit_unit.sv
// rtl/system_flit_unit.sv - multi-channel system flit arbiter, shared FIFO and executor FSM
package types;
    typedef logic [7:0] node_id_t;
    localparam logic [3:0] CMD_PARENT_REQ = 4'h1;
    localparam logic [3:0] CMD_PARENT_ACK = 4'h2;
    localparam logic [3:0] CMD_ID_REQ     = 4'h3;
    localparam logic [3:0] CMD_ID_ACK     = 4'h4;
    typedef struct packed {
        logic [3:0] sys_cmd;
        node_id_t   src;
        node_id_t   dst;
        node_id_t   payload;
    } flit_t;
endpackage

module system_flit_unit #(
    parameter int NUM_CH     = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int ID_WIDTH   = $bits(types::node_id_t),
    parameter int MAX_NODES  = 2**ID_WIDTH,
    parameter int DROP_CNT_W = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         is_root,
    input  logic [ID_WIDTH-1:0]          random_id,
    input  logic [NUM_CH-1:0]            in_valid,
    output logic [NUM_CH-1:0]            in_ready,
    input  types::flit_t [NUM_CH-1:0]    in_flit,
    output logic                         out_valid,
    input  logic                         out_ready,
    output types::flit_t                 out_flit,
    output logic                         out_is_self,
    output logic                         parent_valid,
    output logic [ID_WIDTH-1:0]          parent_id,
    output logic                         node_id_valid,
    output logic [ID_WIDTH-1:0]          node_id,
    output logic                         rt_wr_valid,
    output logic [ID_WIDTH-1:0]          rt_wr_key,
    output logic [ID_WIDTH-1:0]          rt_wr_value,
    output logic [ID_WIDTH-1:0]          id_counter,
    output logic [DROP_CNT_W-1:0]        drop_count,
    output logic                         busy
);
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int AW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = ID_WIDTH + 1;

    typedef enum logic [1:0] {S_IDLE, S_DECODE, S_EMIT, S_COMMIT} state_t;

    state_t                state_q, state_d;
    logic [CH_W-1:0]       ptr_q, ptr_d;
    logic                  en_q;
    types::flit_t          fifo_q [FIFO_DEPTH];
    types::flit_t          fifo_d [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]           count_q, count_d;
    types::flit_t          cur_q, cur_d, out_flit_q, out_flit_d, resp;
    logic                  out_valid_q, out_valid_d, out_is_self_q, out_is_self_d;
    logic                  pend_parent_q, pend_parent_d, pend_node_q, pend_node_d;
    logic                  pend_rt_q, pend_rt_d, pend_inc_q, pend_inc_d, pend_drop_q, pend_drop_d;
    logic [ID_WIDTH-1:0]   pend_id_q, pend_id_d;
    logic                  parent_valid_q, parent_valid_d, node_id_valid_q, node_id_valid_d;
    logic [ID_WIDTH-1:0]   parent_id_q, parent_id_d, node_id_q, node_id_d;
    logic                  rt_wr_valid_q, rt_wr_valid_d;
    logic [ID_WIDTH-1:0]   rt_wr_key_q, rt_wr_key_d, rt_wr_value_q, rt_wr_value_d;
    logic [CNT_W-1:0]      id_cnt_q, id_cnt_d;
    logic [DROP_CNT_W-1:0] drop_q, drop_d;

    logic [CH_W-1:0]       cand [NUM_CH];
    logic [CH_W-1:0]       gnt_idx;
    logic                  found, pop, can_accept, push, bypass, fifo_wr, emit;
    logic [ID_WIDTH-1:0]   self_id;

    assign self_id = node_id_valid_q ? node_id_q : random_id;

    // Round-robin search starting at the channel after the last one served.
    always_comb begin
        gnt_idx = '0;
        found   = 1'b0;
        for (int k = 0; k < NUM_CH; k++) begin
            cand[k] = CH_W'((int'(ptr_q) + k) % NUM_CH);
            if (!found && in_valid[cand[k]]) begin
                found   = 1'b1;
                gnt_idx = cand[k];
            end
        end
    end

    assign pop        = (state_q == S_IDLE) && (count_q != '0);
    assign can_accept = en_q && ((count_q != (AW+1)'(FIFO_DEPTH)) || pop);
    assign push       = can_accept && found;
    assign in_ready   = push ? (NUM_CH'(1) << gnt_idx) : '0;
    // An empty FIFO with an idle FSM hands the arriving flit straight to DECODE.
    assign bypass     = push && (state_q == S_IDLE) && (count_q == '0);
    assign fifo_wr    = push && !bypass;

    always_comb begin
        fifo_d   = fifo_q;
        if (fifo_wr) fifo_d[wr_ptr_q] = in_flit[gnt_idx];
        wr_ptr_d = wr_ptr_q + AW'(fifo_wr);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        count_d  = count_q + (AW+1)'(fifo_wr) - (AW+1)'(pop);
        ptr_d    = ptr_q;
        if (push) ptr_d = (int'(gnt_idx) == NUM_CH - 1) ? '0 : gnt_idx + CH_W'(1);
    end

    always_comb begin
        state_d         = state_q;
        cur_d           = cur_q;
        out_valid_d     = out_valid_q;
        out_flit_d      = out_flit_q;
        out_is_self_d   = out_is_self_q;
        pend_parent_d   = pend_parent_q;
        pend_node_d     = pend_node_q;
        pend_rt_d       = pend_rt_q;
        pend_inc_d      = pend_inc_q;
        pend_drop_d     = pend_drop_q;
        pend_id_d       = pend_id_q;
        parent_valid_d  = parent_valid_q;
        parent_id_d     = parent_id_q;
        node_id_valid_d = node_id_valid_q;
        node_id_d       = node_id_q;
        rt_wr_valid_d   = 1'b0;
        rt_wr_key_d     = rt_wr_key_q;
        rt_wr_value_d   = rt_wr_value_q;
        id_cnt_d        = id_cnt_q;
        drop_d          = drop_q;
        emit            = 1'b0;
        resp            = '0;
        resp.src        = self_id;
        resp.dst        = cur_q.src;
        case (state_q)
            S_IDLE: begin
                if (pop) begin
                    cur_d   = fifo_q[rd_ptr_q];
                    state_d = S_DECODE;
                end else if (bypass) begin
                    cur_d   = in_flit[gnt_idx];
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                pend_parent_d = 1'b0;
                pend_node_d   = 1'b0;
                pend_rt_d     = 1'b0;
                pend_inc_d    = 1'b0;
                pend_drop_d   = 1'b0;
                out_is_self_d = 1'b0;
                case (cur_q.sys_cmd)
                    types::CMD_PARENT_REQ: begin
                        resp.sys_cmd = types::CMD_PARENT_ACK;
                        emit         = is_root || parent_valid_q;
                        pend_drop_d  = !emit;
                        out_flit_d   = resp;
                    end
                    types::CMD_PARENT_ACK: begin
                        pend_parent_d = !parent_valid_q && (cur_q.dst == node_id);
                        pend_id_d     = cur_q.src;
                    end
                    types::CMD_ID_REQ: begin
                        if (is_root) begin
                            resp.sys_cmd = types::CMD_ID_ACK;
                            resp.payload = id_cnt_q[ID_WIDTH-1:0];
                            emit         = id_cnt_q < CNT_W'(MAX_NODES);
                            pend_rt_d    = emit;
                            pend_inc_d   = emit;
                            rt_wr_key_d  = id_cnt_q[ID_WIDTH-1:0];
                            rt_wr_value_d = cur_q.src;
                            out_flit_d   = resp;
                        end else begin
                            emit           = parent_valid_q;
                            out_flit_d     = cur_q;
                            out_flit_d.dst = parent_id_q;
                        end
                        pend_drop_d = !emit;
                    end
                    types::CMD_ID_ACK: begin
                        out_flit_d = cur_q;
                        if ((cur_q.dst == random_id) && !node_id_valid_q) begin
                            emit          = 1'b1;
                            out_is_self_d = 1'b1;
                            pend_node_d   = 1'b1;
                            pend_id_d     = cur_q.payload;
                        end else if (node_id_valid_q) begin
                            emit          = 1'b1;
                            pend_rt_d     = 1'b1;
                            rt_wr_key_d   = cur_q.payload;
                            rt_wr_value_d = cur_q.src;
                        end else begin
                            pend_drop_d = 1'b1;
                        end
                    end
                    default: pend_drop_d = 1'b1;
                endcase
                out_valid_d = emit;
                state_d     = emit ? S_EMIT : S_COMMIT;
            end
            S_EMIT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_COMMIT;
                end
            end
            S_COMMIT: begin
                if (pend_parent_q) begin
                    parent_valid_d = 1'b1;
                    parent_id_d    = pend_id_q;
                end
                if (pend_node_q) begin
                    node_id_valid_d = 1'b1;
                    node_id_d       = pend_id_q;
                end
                rt_wr_valid_d = pend_rt_q;
                if (pend_inc_q) id_cnt_d = id_cnt_q + CNT_W'(1);
                if (pend_drop_q && (drop_q != '1)) drop_d = drop_q + DROP_CNT_W'(1);
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;   ptr_q <= '0;   en_q <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= '0;
            wr_ptr_q <= '0;      rd_ptr_q <= '0;   count_q <= '0;
            cur_q <= '0;         out_flit_q <= '0;
            out_valid_q <= 1'b0; out_is_self_q <= 1'b0;
            pend_parent_q <= 1'b0; pend_node_q <= 1'b0; pend_rt_q <= 1'b0;
            pend_inc_q <= 1'b0;  pend_drop_q <= 1'b0; pend_id_q <= '0;
            parent_valid_q <= 1'b0; parent_id_q <= '0;
            node_id_valid_q <= 1'b0; node_id_q <= '0;
            rt_wr_valid_q <= 1'b0; rt_wr_key_q <= '0; rt_wr_value_q <= '0;
            id_cnt_q <= CNT_W'(1); drop_q <= '0;
        end else begin
            state_q <= state_d;  ptr_q <= ptr_d;   en_q <= 1'b1;
            fifo_q <= fifo_d;
            wr_ptr_q <= wr_ptr_d; rd_ptr_q <= rd_ptr_d; count_q <= count_d;
            cur_q <= cur_d;      out_flit_q <= out_flit_d;
            out_valid_q <= out_valid_d; out_is_self_q <= out_is_self_d;
            pend_parent_q <= pend_parent_d; pend_node_q <= pend_node_d; pend_rt_q <= pend_rt_d;
            pend_inc_q <= pend_inc_d; pend_drop_q <= pend_drop_d; pend_id_q <= pend_id_d;
            parent_valid_q <= parent_valid_d; parent_id_q <= parent_id_d;
            node_id_valid_q <= node_id_valid_d; node_id_q <= node_id_d;
            rt_wr_valid_q <= rt_wr_valid_d; rt_wr_key_q <= rt_wr_key_d; rt_wr_value_q <= rt_wr_value_d;
            id_cnt_q <= id_cnt_d; drop_q <= drop_d;
        end
    end

    assign out_valid     = out_valid_q;
    assign out_flit      = out_flit_q;
    assign out_is_self   = out_is_self_q;
    assign parent_valid  = parent_valid_q;
    assign parent_id     = parent_id_q;
    assign node_id_valid = node_id_valid_q;
    assign node_id       = node_id_valid_q ? node_id_q : (is_root ? '0 : random_id);
    assign rt_wr_valid   = rt_wr_valid_q;
    assign rt_wr_key     = rt_wr_key_q;
    assign rt_wr_value   = rt_wr_value_q;
    // The counter carries one extra bit so it can rest at MAX_NODES without wrapping.
    assign id_counter    = id_cnt_q[ID_WIDTH-1:0];
    assign drop_count    = drop_q;
    assign busy          = (state_q != S_IDLE) || (count_q != '0);
endmodule

// File: tb/tb_system_flit_unit.sv
// tb/tb_system_flit_unit.sv - randomized and directed bench for system_flit_unit
module tb_system_flit_unit;
    import types::*;
    localparam int NCH  = 4;
    localparam int MAXN = 256;

    logic clk = 1'b0, rst_n = 1'b0, is_root = 1'b0, out_ready = 1'b0;
    logic [7:0] random_id = 8'h5A;
    logic [NCH-1:0] in_valid = '0, in_ready;
    flit_t [NCH-1:0] in_flit;
    flit_t out_flit;
    logic out_valid, out_is_self, parent_valid, node_id_valid, rt_wr_valid, busy;
    logic [7:0] parent_id, node_id, rt_wr_key, rt_wr_value, id_counter, drop_count;

    always #5 clk = ~clk;

    system_flit_unit dut (
        .clk(clk), .rst_n(rst_n), .is_root(is_root), .random_id(random_id),
        .in_valid(in_valid), .in_ready(in_ready), .in_flit(in_flit),
        .out_valid(out_valid), .out_ready(out_ready), .out_flit(out_flit), .out_is_self(out_is_self),
        .parent_valid(parent_valid), .parent_id(parent_id),
        .node_id_valid(node_id_valid), .node_id(node_id),
        .rt_wr_valid(rt_wr_valid), .rt_wr_key(rt_wr_key), .rt_wr_value(rt_wr_value),
        .id_counter(id_counter), .drop_count(drop_count), .busy(busy)
    );

    int errors = 0, checks = 0;
    bit mon_en = 1'b0;
    bit m_pv, m_nv, last_self;
    logic [7:0] m_pid, m_node;
    int m_cnt, m_drop, m_ptr, rt_cnt, mg, ma;
    logic [28:0] exp_out[$];
    logic [15:0] exp_rt[$];
    flit_t out_log[$];
    int acc_log[$];
    int rnd [NCH];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic flit_t mk(input logic [3:0] c, input logic [7:0] s, input logic [7:0] d, input logic [7:0] p);
        flit_t f;
        f.sys_cmd = c; f.src = s; f.dst = d; f.payload = p;
        return f;
    endfunction

    function automatic void model_clear();
        m_pv = 0; m_nv = 0; m_pid = 0; m_node = 0; m_cnt = 1; m_drop = 0; m_ptr = 0; rt_cnt = 0;
        exp_out.delete(); exp_rt.delete(); out_log.delete(); acc_log.delete();
    endfunction

    function automatic void model_drop();
        if (m_drop < 255) m_drop++;
    endfunction

    // Transaction-level meaning of one accepted flit, applied in acceptance order.
    function automatic void model_process(input flit_t f);
        logic [7:0] self_id, cur_id;
        flit_t r;
        self_id = m_nv ? m_node : random_id;
        cur_id  = m_nv ? m_node : (is_root ? 8'h00 : random_id);
        case (f.sys_cmd)
            CMD_PARENT_REQ:
                if (is_root || m_pv) exp_out.push_back({1'b0, mk(CMD_PARENT_ACK, self_id, f.src, 8'h00)});
                else model_drop();
            CMD_PARENT_ACK:
                if (!m_pv && f.dst == cur_id) begin m_pv = 1; m_pid = f.src; end
            CMD_ID_REQ:
                if (is_root) begin
                    if (m_cnt < MAXN) begin
                        exp_out.push_back({1'b0, mk(CMD_ID_ACK, self_id, f.src, 8'(m_cnt))});
                        exp_rt.push_back({8'(m_cnt), f.src});
                        m_cnt++;
                    end else model_drop();
                end else if (m_pv) begin
                    r = f; r.dst = m_pid;
                    exp_out.push_back({1'b0, r});
                end else model_drop();
            CMD_ID_ACK:
                if (f.dst == random_id && !m_nv) begin
                    m_nv = 1; m_node = f.payload;
                    exp_out.push_back({1'b1, f});
                end else if (m_nv) begin
                    exp_out.push_back({1'b0, f});
                    exp_rt.push_back({f.payload, f.src});
                end else model_drop();
            default: model_drop();
        endcase
    endfunction

    always @(negedge clk) begin
        if (mon_en && rst_n) begin
            if (in_ready != '0) begin
                mg = -1;
                for (int k = 0; k < NCH; k++)
                    if (mg < 0 && in_valid[(m_ptr + k) % NCH]) mg = (m_ptr + k) % NCH;
                check("arb_grant", 32'(in_ready), (mg < 0) ? 32'h0 : (32'h1 << mg));
                ma = -1;
                for (int k = 0; k < NCH; k++) if (ma < 0 && in_valid[k] && in_ready[k]) ma = k;
                if (ma >= 0) begin
                    acc_log.push_back(ma);
                    m_ptr = (ma + 1) % NCH;
                    model_process(in_flit[ma]);
                end
            end
            if (out_valid && out_ready) begin
                if (exp_out.size() == 0) check("out_unexpected", 32'(out_flit), 32'h0);
                else check("out_flit", 32'({out_is_self, out_flit}), 32'(exp_out.pop_front()));
                out_log.push_back(out_flit);
                last_self = out_is_self;
            end
            if (rt_wr_valid) begin
                rt_cnt++;
                if (exp_rt.size() == 0) check("rt_unexpected", 32'({rt_wr_key, rt_wr_value}), 32'h0);
                else check("rt_write", 32'({rt_wr_key, rt_wr_value}), 32'(exp_rt.pop_front()));
            end
        end
    end

    task automatic do_reset(input bit root);
        mon_en = 0; rst_n = 0; in_valid = '0; out_ready = 0; is_root = root;
        repeat (3) @(posedge clk);
        model_clear();
        @(negedge clk); rst_n = 1;
        @(posedge clk); #1; mon_en = 1;
    endtask

    task automatic send(input int ch, input flit_t f);
        bit ok = 0;
        in_flit[ch] = f; in_valid[ch] = 1'b1;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk); if (in_ready[ch]) ok = 1;
            @(posedge clk); #1;
        end
        in_valid[ch] = 1'b0;
        if (!ok) check("send_timeout", 32'(ok), 32'h1);
    endtask

    task automatic wait_idle(input int budget);
        bit ok = 0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk); if (!busy && !out_valid) ok = 1;
        end
        check("idle_reached", 32'(ok), 32'h1);
        @(posedge clk); #1;
    endtask

    function automatic flit_t gen(input int ch, input int mode);
        logic [3:0] cmds [9];
        cmds = '{4'h1, 4'h1, 4'h2, 4'h3, 4'h3, 4'h4, 4'h4, 4'h0, 4'h9};
        case (mode)
            1: begin rnd[ch]++; return mk(CMD_PARENT_REQ, 8'(16 * rnd[ch] + ch), 8'h00, 8'h00); end
            2: return mk(4'hF, 8'($urandom), 8'($urandom), 8'($urandom));
            default: return mk(cmds[$urandom_range(8)], 8'($urandom),
                               $urandom_range(1) ? random_id : 8'($urandom), 8'($urandom));
        endcase
    endfunction

    task automatic run_traffic(input int n, input int pct, input int mode, input bit rand_ready);
        logic [NCH-1:0] acc;
        for (int i = 0; i < n; i++) begin
            @(negedge clk); acc = in_valid & in_ready;
            @(posedge clk); #1;
            for (int ch = 0; ch < NCH; ch++)
                if (acc[ch] || !in_valid[ch]) begin
                    if (int'($urandom_range(99)) < pct) begin
                        in_valid[ch] = 1'b1; in_flit[ch] = gen(ch, mode);
                    end else in_valid[ch] = 1'b0;
                end
            if (rand_ready) out_ready = ($urandom_range(99) < 70);
        end
    endtask

    task automatic check_model_regs();
        check("m_parent_valid", 32'(parent_valid), 32'(m_pv));
        if (m_pv) check("m_parent_id", 32'(parent_id), 32'(m_pid));
        check("m_node_valid", 32'(node_id_valid), 32'(m_nv));
        check("m_node_id", 32'(node_id), 32'(m_nv ? m_node : (is_root ? 8'h00 : random_id)));
        check("m_id_counter", 32'(id_counter), 32'(8'(m_cnt)));
        check("m_drop_count", 32'(drop_count), 32'(m_drop));
        check("m_out_pending", 32'(exp_out.size()), 32'h0);
        check("m_rt_pending", 32'(exp_rt.size()), 32'h0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        in_flit = '0;
        for (int ch = 0; ch < NCH; ch++) rnd[ch] = 0;
        model_clear();
        // Reset state, with all channels requesting
        in_valid = '1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'h0);
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_id_counter", 32'(id_counter), 32'h1);
        check("rst_drop", 32'(drop_count), 32'h0);
        check("rst_parent_valid", 32'(parent_valid), 32'h0);
        check("rst_node_valid", 32'(node_id_valid), 32'h0);
        check("rst_rt_valid", 32'(rt_wr_valid), 32'h0);
        in_valid = '0;

        // Root id assignment
        do_reset(1);
        in_flit[2] = mk(CMD_ID_REQ, 8'h21, 8'h00, 8'h00); in_valid[2] = 1'b1;
        @(negedge clk); check("assign_ready", 32'(in_ready), 32'h4);
        @(posedge clk); #1; in_valid[2] = 1'b0;
        @(negedge clk); check("assign_decode_quiet", 32'(out_valid), 32'h0);
        @(negedge clk); check("assign_out_valid", 32'(out_valid), 32'h1);
        check("assign_out_flit", 32'(out_flit), 32'(mk(CMD_ID_ACK, 8'h5A, 8'h21, 8'h01)));
        @(posedge clk); #1; out_ready = 1;
        @(negedge clk);
        @(posedge clk); #1; out_ready = 0;
        @(negedge clk); check("assign_rt_early", 32'(rt_wr_valid), 32'h0);
        @(negedge clk);
        check("assign_rt_pulse", 32'({rt_wr_valid, rt_wr_key, rt_wr_value}), 32'h10121);
        check("assign_id_counter", 32'(id_counter), 32'h2);
        @(negedge clk); check("assign_rt_once", 32'(rt_wr_valid), 32'h0);
        @(posedge clk); #1;

        // Join flow on a non-root node
        do_reset(0);
        check("join_temp_id", 32'(node_id), 32'h5A);
        send(0, mk(CMD_PARENT_ACK, 8'h05, 8'h5A, 8'h00));
        wait_idle(50);
        check("join_parent", 32'({parent_valid, parent_id}), 32'h105);
        out_ready = 1;
        send(1, mk(CMD_ID_ACK, 8'h00, 8'h5A, 8'h07));
        wait_idle(50);
        check("join_node", 32'({node_id_valid, node_id}), 32'h107);
        check("join_self", 32'(last_self), 32'h1);
        check("join_out_count", 32'(out_log.size()), 32'h1);
        check_model_regs();

        // Arbitration order and backpressure
        do_reset(1);
        for (int ch = 0; ch < NCH; ch++) rnd[ch] = 0;
        run_traffic(8, 100, 1, 0);
        @(negedge clk); check("arb_full_ready", 32'(in_ready), 32'h0);
        @(posedge clk); #1; in_valid = '0;
        check("arb_accepts", 32'(acc_log.size()), 32'h5);
        for (int i = 0; i < 5 && i < acc_log.size(); i++)
            check("arb_order", 32'(acc_log[i]), 32'(i % 4));
        out_ready = 1;
        wait_idle(200);
        check("arb_drained", 32'(out_log.size()), 32'h5);
        for (int i = 0; i < 5 && i < out_log.size(); i++)
            check("arb_drain_dst", 32'(out_log[i].dst), (i < 4) ? 32'(8'h10 + i) : 32'h20);

        // Id counter exhaustion
        do_reset(1);
        out_ready = 1;
        for (int i = 0; i < MAXN - 2; i++) send(i % NCH, mk(CMD_ID_REQ, 8'(i), 8'h00, 8'h00));
        wait_idle(200);
        check("exh_counter", 32'(id_counter), 32'hFF);
        rt_cnt = 0; out_log.delete();
        send(0, mk(CMD_ID_REQ, 8'h33, 8'h00, 8'h00));
        send(1, mk(CMD_ID_REQ, 8'h44, 8'h00, 8'h00));
        wait_idle(100);
        check("exh_out_count", 32'(out_log.size()), 32'h1);
        if (out_log.size() > 0)
            check("exh_last_id", 32'({out_log[0].dst, out_log[0].payload}), 32'h33FF);
        check("exh_drop", 32'(drop_count), 32'h1);
        check("exh_rt_count", 32'(rt_cnt), 32'h1);

        // Drops and saturation
        do_reset(0);
        out_ready = 1;
        send(0, mk(4'hF, 8'h01, 8'h02, 8'h03));
        send(1, mk(CMD_PARENT_REQ, 8'h09, 8'h5A, 8'h00));
        wait_idle(50);
        check("drop_two", 32'(drop_count), 32'h2);
        check("drop_no_out", 32'(out_log.size()), 32'h0);
        run_traffic(1000, 100, 2, 0);
        in_valid = '0;
        wait_idle(100);
        check("drop_saturate", 32'(drop_count), 32'hFF);
        check("drop_model", 32'(drop_count), 32'(m_drop));

        // Asynchronous reset while stalled in EMIT with a loaded FIFO
        do_reset(1);
        for (int ch = 0; ch < NCH; ch++) rnd[ch] = 0;
        run_traffic(4, 100, 1, 0);
        @(negedge clk);
        check("mid_busy_before", 32'({busy, out_valid}), 32'h3);
        #2; mon_en = 0; rst_n = 0; in_valid = '0;
        #1;
        check("mid_out_valid", 32'(out_valid), 32'h0);
        check("mid_busy", 32'(busy), 32'h0);
        check("mid_id_counter", 32'(id_counter), 32'h1);
        check("mid_drop", 32'(drop_count), 32'h0);
        model_clear();
        @(negedge clk); rst_n = 1;
        @(posedge clk); #1; mon_en = 1; out_ready = 1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("mid_fifo_discarded", 32'({busy, out_valid}), 32'h0);
        @(posedge clk); #1;

        // Randomized traffic against the model, root then non-root
        for (int pass = 0; pass < 2; pass++) begin
            random_id = 8'($urandom_range(1, 255));
            do_reset(pass == 0);
            run_traffic(1500, 40, 0, 1);
            in_valid = '0; out_ready = 1;
            wait_idle(500);
            check_model_regs();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
